// File: rtl/echo_request_pipe_fifo_if.sv
// echo_request_pipe_fifo_if: one ENA/RDY method-call channel carrying a
// 96-bit tagged request message ([31:0] tag, [63:32] meth, [95:64] v).
//   enq__ENA  caller invokes the method this cycle
//   enq_v     message carried by the call
//   enq__RDY  method guard, driven by the callee
interface echo_request_pipe_fifo_if;
    logic        enq__ENA;
    logic [95:0] enq_v;
    logic        enq__RDY;

    // Caller side: invokes enq, observes the guard.
    modport master (
        output enq__ENA,
        output enq_v,
        input  enq__RDY
    );

    // Callee side: provides the guard, receives the call.
    modport slave (
        input  enq__ENA,
        input  enq_v,
        output enq__RDY
    );
endinterface

// File: rtl/echo_request_pipe_fifo.sv
// echo_request_pipe_fifo: DEPTH-entry in-order request buffer that drops
// messages whose tag is not say(1)/say2(2) and counts the drops.
//   CLK, nRST   clock, async active-low reset
//   pipe        slave enq channel from the request serializer
//   out         master enq channel to the request demultiplexer
//   count       current occupancy 0..DEPTH
//   drop_count  saturating count of discarded messages
module echo_request_pipe_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        nRST,
    echo_request_pipe_fifo_if.slave     pipe,
    echo_request_pipe_fifo_if.master    out,
    output logic [$clog2(DEPTH):0]      count,
    output logic [15:0]                 drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [95:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_next;

    logic [31:0] tag;
    logic        tag_ok;
    logic        acc;
    logic        wr;
    logic        drop;
    logic        deq;

    // Guard derives from the count register only, so a full FIFO
    // refuses enq even when a dequeue happens in the same cycle.
    assign pipe.enq__RDY = (count != FULL);

    assign tag    = pipe.enq_v[31:0];
    assign tag_ok = (tag == 32'd1) || (tag == 32'd2);

    assign acc  = pipe.enq__ENA & pipe.enq__RDY;
    assign wr   = acc & tag_ok;
    assign drop = acc & ~tag_ok;

    assign deq          = (count != '0) & out.enq__RDY;
    assign out.enq__ENA = deq;
    assign out.enq_v    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        unique case (1'b1)
            (wr & ~deq): count_next = count + CW'(1);
            (deq & ~wr): count_next = count - CW'(1);
            default:     count_next = count;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            count <= count_next;
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (deq)
                rd_ptr <= rd_ptr + AW'(1);
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    // Storage is deliberately not reset; occupancy gates its use.
    always_ff @(posedge CLK) begin
        if (wr)
            mem[wr_ptr] <= pipe.enq_v;
    end
endmodule

// File: tb/tb_echo_request_pipe_fifo.sv
// tb_echo_request_pipe_fifo: directed stimulus with a queue scoreboard;
// a negedge monitor checks every dequeued message against the queue.
module tb_echo_request_pipe_fifo;
    logic        CLK;
    logic        nRST;
    logic [2:0]  count;
    logic [15:0] drop_count;

    echo_request_pipe_fifo_if pipe_if ();
    echo_request_pipe_fifo_if out_if ();

    echo_request_pipe_fifo #(.DEPTH(4)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .pipe       (pipe_if),
        .out        (out_if),
        .count      (count),
        .drop_count (drop_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [95:0] exp_q [$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [95:0] mk(input logic [31:0] tag,
                                       input logic [31:0] meth);
        return {32'hC0DE_0000 + meth, meth, tag};
    endfunction

    task automatic send(input logic [31:0] tag, input logic [31:0] meth,
                        input bit push);
        pipe_if.enq__ENA = 1'b1;
        pipe_if.enq_v    = mk(tag, meth);
        if (push)
            exp_q.push_back(mk(tag, meth));
    endtask

    task automatic idle();
        pipe_if.enq__ENA = 1'b0;
    endtask

    // Monitor: a message presented with ENA high is taken at the next edge.
    always @(negedge CLK) begin
        if (nRST && out_if.enq__ENA) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", out_if.enq_v, 96'h0);
                if (out_if.enq_v == 96'h0)
                    chk("unexpected_out_flag", 96'h1, 96'h0);
            end else begin
                chk("out_msg", out_if.enq_v, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST             = 1'b0;
        pipe_if.enq__ENA = 1'b0;
        pipe_if.enq_v    = '0;
        out_if.enq__RDY  = 1'b0;
        repeat (2) @(posedge CLK);
        #3;
        nRST = 1'b1;
        tick();
        chk("rst_count", 96'(count), 96'd0);
        chk("rst_rdy", 96'(pipe_if.enq__RDY), 96'd1);
        chk("rst_out_ena", 96'(out_if.enq__ENA), 96'd0);
        chk("rst_drop", 96'(drop_count), 96'd0);

        // Streaming with downstream always ready.
        out_if.enq__RDY = 1'b1;
        send(32'd1, 32'h10, 1'b1); tick();
        chk("lat_out_ena", 96'(out_if.enq__ENA), 96'd1);
        chk("s_count0", 96'(count), 96'd1);
        send(32'd2, 32'h11, 1'b1); tick();
        chk("s_count1", 96'(count), 96'd1);
        send(32'd1, 32'h12, 1'b1); tick();
        chk("s_count2", 96'(count), 96'd1);
        send(32'd2, 32'h13, 1'b1); tick();
        chk("s_count3", 96'(count), 96'd1);
        idle(); tick();
        chk("s_count_end", 96'(count), 96'd0);

        // Fill to DEPTH with downstream stalled; fifth call refused.
        out_if.enq__RDY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(32'd1, 32'h20 + i, 1'b1);
            tick();
        end
        chk("full_count", 96'(count), 96'd4);
        chk("full_rdy", 96'(pipe_if.enq__RDY), 96'd0);
        send(32'd1, 32'h24, 1'b0); tick();
        chk("viol_count", 96'(count), 96'd4);
        idle();
        out_if.enq__RDY = 1'b1;
        repeat (4) tick();
        chk("drain_count", 96'(count), 96'd0);
        chk("drain_rdy", 96'(pipe_if.enq__RDY), 96'd1);

        // Full with simultaneous dequeue: no pass-through.
        out_if.enq__RDY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(32'd2, 32'h30 + i, 1'b1);
            tick();
        end
        out_if.enq__RDY = 1'b1;
        send(32'd1, 32'h34, 1'b0);
        chk("fd_rdy_same", 96'(pipe_if.enq__RDY), 96'd0);
        tick();
        chk("fd_count", 96'(count), 96'd3);
        chk("fd_rdy_next", 96'(pipe_if.enq__RDY), 96'd1);
        idle();
        repeat (3) tick();
        chk("fd_empty", 96'(count), 96'd0);

        // Invalid tags are consumed and counted.
        send(32'd0, 32'h40, 1'b0); tick();
        chk("inv_count0", 96'(count), 96'd0);
        send(32'd3, 32'h41, 1'b0); tick();
        chk("inv_count1", 96'(count), 96'd0);
        send(32'hFFFF_FFFF, 32'h42, 1'b0); tick();
        chk("inv_count2", 96'(count), 96'd0);
        send(32'd1, 32'h43, 1'b1); tick();
        chk("inv_count3", 96'(count), 96'd1);
        idle(); tick();
        chk("inv_count4", 96'(count), 96'd0);
        chk("inv_drop", 96'(drop_count), 96'd3);

        // Drive drop_count to saturation.
        for (int i = 0; i < 32'hFFFB; i++) begin
            send(32'd0, 32'(i), 1'b0);
            tick();
        end
        idle();
        chk("sat_pre", 96'(drop_count), 96'hFFFE);
        for (int i = 0; i < 3; i++) begin
            send(32'd5, 32'h50, 1'b0);
            tick();
            chk("sat_hold", 96'(drop_count), 96'hFFFF);
        end
        idle(); tick();

        // Asynchronous reset mid-operation discards buffered messages.
        out_if.enq__RDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(32'd1, 32'h60 + i, 1'b0);
            tick();
        end
        idle();
        chk("pre_rst_count", 96'(count), 96'd3);
        #1;
        out_if.enq__RDY = 1'b1;
        #1;
        nRST = 1'b0;
        #1;
        chk("arst_count", 96'(count), 96'd0);
        chk("arst_rdy", 96'(pipe_if.enq__RDY), 96'd1);
        chk("arst_out_ena", 96'(out_if.enq__ENA), 96'd0);
        chk("arst_drop", 96'(drop_count), 96'd0);
        #3;
        nRST = 1'b1;
        tick();
        send(32'd2, 32'h70, 1'b1); tick();
        chk("post_rst_count", 96'(count), 96'd1);
        idle(); tick();
        chk("post_rst_empty", 96'(count), 96'd0);
        repeat (2) tick();
        chk("sb_empty", 96'(exp_q.size()), 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
